bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using iterative shift-and-add-3 (double dabble), one input bit per clock.
- Sits directly downstream of the data_processing datapath: consumes its 32-bit out_data result and produces packed BCD digits for the seven-segment display driver.
- Uses a start/busy/done handshake so the controlling FSM can launch a conversion once a result is final.

---
 rtl/bin2bcd_seq_if.sv | 22 ++
 rtl/bin2bcd_seq.sv | 108 ++++++++++
 tb/tb_bin2bcd_seq.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_if.sv
// rtl/bin2bcd_seq_if.sv - start/busy/done handshake bundle for the binary-to-BCD converter
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
);
  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, overflow
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, overflow
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - iterative double-dabble binary-to-BCD converter, one input bit per clock
module bin2bcd_seq #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input logic          clk,
  input logic          rst,
  bin2bcd_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  shift_reg;
  logic [BW-1:0]     scratch;
  logic [CW-1:0]     cnt;
  logic              sticky;
  logic [BW-1:0]     bcd_q;
  logic              ovf_q;
  logic              busy_c;
  logic              done_c;

  logic [BW-1:0]     adj;
  logic [BW-1:0]     scratch_sh;
  logic [WIDTH-1:0]  shift_sh;
  logic              out_bit;
  logic              last_shift;

  // Per-digit add-3 correction; digits never carry into each other.
  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    assign adj[4*d +: 4] = (scratch[4*d +: 4] >= 4'd5) ? scratch[4*d +: 4] + 4'd3
                                                       : scratch[4*d +: 4];
  end

  assign out_bit    = adj[BW-1];
  assign scratch_sh = {adj[BW-2:0], shift_reg[WIDTH-1]};
  assign shift_sh   = {shift_reg[WIDTH-2:0], 1'b0};
  assign last_shift = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_n = SHIFT;
      end
      SHIFT: begin
        busy_c = 1'b1;
        if (last_shift) state_n = DONE;
      end
      DONE: begin
        done_c  = 1'b1;
        state_n = bus.start ? SHIFT : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      scratch   <= '0;
      cnt       <= '0;
      sticky    <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            shift_reg <= bus.bin_in;
            scratch   <= '0;
            sticky    <= 1'b0;
            cnt       <= CW'(WIDTH);
          end
        end
        SHIFT: begin
          shift_reg <= shift_sh;
          scratch   <= scratch_sh;
          sticky    <= sticky | out_bit;
          cnt       <= cnt - CW'(1);
          // Result is published on the edge that enters DONE.
          if (last_shift) begin
            bcd_q <= scratch_sh;
            ovf_q <= sticky | out_bit;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = busy_c;
  assign bus.done     = done_c;
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - scoreboard bench for bin2bcd_seq at 32/10 and 8/2 configurations
module tb_bin2bcd_seq;
  logic clk;
  logic rst;

  bin2bcd_seq_if #(.WIDTH(32), .DIGITS(10)) big ();
  bin2bcd_seq_if #(.WIDTH(8),  .DIGITS(2))  sml ();

  bin2bcd_seq #(.WIDTH(32), .DIGITS(10)) dut32 (.clk(clk), .rst(rst), .bus(big));
  bin2bcd_seq #(.WIDTH(8),  .DIGITS(2))  dut8  (.clk(clk), .rst(rst), .bus(sml));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t        q32[$];
  exp_t        q8[$];
  int          checks = 0;
  int          errors = 0;
  logic [39:0] prev32 = '0;
  logic [39:0] prev8  = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input longint unsigned v, input int digits);
    exp_t            e;
    longint unsigned x;
    e.bcd = '0;
    x = v;
    for (int i = 0; i < digits; i++) begin
      e.bcd[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    e.ovf = (x != 0);
    return e;
  endfunction

  // Drives start at the current negedge; returns at the negedge where done must be high.
  task automatic run32(input logic [31:0] v, input bit poke);
    int   busy_bad = 0;
    int   hold_bad = 0;
    exp_t e;
    big.start  = 1'b1;
    big.bin_in = v;
    q32.push_back(model(v, 10));
    @(negedge clk);
    for (int k = 1; k <= 32; k++) begin
      if (big.busy !== 1'b1 || big.done !== 1'b0) busy_bad++;
      if (big.bcd_out !== prev32) hold_bad++;
      big.start  = poke && (k == 10);
      big.bin_in = big.start ? 32'd99 : $urandom;
      @(negedge clk);
    end
    chk("busy_window32", 64'(busy_bad), 64'd0);
    chk("hold32", 64'(hold_bad), 64'd0);
    chk("done32", 64'(big.done), 64'd1);
    chk("busy_at_done32", 64'(big.busy), 64'd0);
    checks++;
    assert (q32.size() > 0) else begin
      errors++;
      $error("FAIL sb32_empty observed=%0d expected=>0", q32.size());
    end
    if (q32.size() > 0) begin
      e = q32.pop_front();
      chk("bcd32", 64'(big.bcd_out), 64'(e.bcd));
      chk("ovf32", 64'(big.overflow), 64'(e.ovf));
      prev32 = e.bcd;
    end
  endtask

  task automatic run8(input logic [7:0] v);
    int   busy_bad = 0;
    int   hold_bad = 0;
    exp_t e;
    sml.start  = 1'b1;
    sml.bin_in = v;
    q8.push_back(model(64'(v), 2));
    @(negedge clk);
    sml.start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (sml.busy !== 1'b1 || sml.done !== 1'b0) busy_bad++;
      if (40'(sml.bcd_out) !== prev8) hold_bad++;
      sml.bin_in = 8'($urandom);
      @(negedge clk);
    end
    chk("busy_window8", 64'(busy_bad), 64'd0);
    chk("hold8", 64'(hold_bad), 64'd0);
    chk("done8", 64'(sml.done), 64'd1);
    checks++;
    assert (q8.size() > 0) else begin
      errors++;
      $error("FAIL sb8_empty observed=%0d expected=>0", q8.size());
    end
    if (q8.size() > 0) begin
      e = q8.pop_front();
      chk("bcd8", 64'(sml.bcd_out), 64'(e.bcd));
      chk("ovf8", 64'(sml.overflow), 64'(e.ovf));
      prev8 = e.bcd;
    end
  endtask

  task automatic idle32(input int n);
    big.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_done32", 64'(big.done), 64'd0);
      chk("idle_hold32", 64'(big.bcd_out), 64'(prev32));
    end
  endtask

  initial begin
    logic any_done;
    rst        = 1'b1;
    big.start  = 1'b0;
    big.bin_in = '0;
    sml.start  = 1'b0;
    sml.bin_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(big.busy), 64'd0);
    chk("rst_done", 64'(big.done), 64'd0);
    chk("rst_bcd", 64'(big.bcd_out), 64'd0);
    chk("rst_ovf", 64'(big.overflow), 64'd0);
    chk("rst_bcd8", 64'(sml.bcd_out), 64'd0);

    run32(32'd0, 1'b0);
    idle32(2);
    run32(32'hFFFF_FFFF, 1'b0);
    chk("max_literal", 64'(big.bcd_out), 64'h42_9496_7295);
    idle32(1);
    run32(32'd12345, 1'b1);
    idle32(1);
    run32(32'd6765, 1'b0);
    run32(32'd832040, 1'b0);
    chk("f30_literal", 64'(big.bcd_out), 64'h83_2040);
    idle32(2);

    // Abort a conversion of 55 partway through with reset.
    big.start  = 1'b1;
    big.bin_in = 32'd55;
    @(negedge clk);
    big.start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_abort_busy", 64'(big.busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(big.busy), 64'd0);
    chk("abort_bcd", 64'(big.bcd_out), 64'd0);
    chk("abort_ovf", 64'(big.overflow), 64'd0);
    prev32   = '0;
    any_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      any_done |= big.done;
      @(negedge clk);
    end
    chk("abort_no_done", 64'(any_done), 64'd0);
    run32(32'd55, 1'b0);
    chk("f10_literal", 64'(big.bcd_out), 64'h55);
    idle32(1);

    run8(8'd255);
    chk("trunc_literal", 64'(sml.bcd_out), 64'h55);
    sml.start = 1'b0;
    @(negedge clk);
    run8(8'd99);
    run8(8'd100);
    sml.start = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
